pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised, elastic successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload of DATA_W bits between two stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so upstream ready is a registered signal.
- Also honours the legacy stall vector and flush, and keeps saturating bubble/back-pressure counters for performance analysis.

Parameters:
- DATA_W, 128: payload width in bits. Packed struct of pc, rd, wreg, wdata, ctrl, etc.
- STAGE_NUM, 6: width of the legacy stall vector.
- STAGE_IDX, 3: index of the consuming stage in the stall vector. Must be 1..STAGE_NUM-1.
- ZERO_INVALID, 1: when 1, out_data is forced to all-zero whenever out_valid=0 (bubble = NOP payload).
- CNT_W, 16: width of the performance counters.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: reset. Asynchronous, active-low.
- in_valid, in, 1: upstream payload valid.
- in_ready, out, 1: buffer can accept a payload. Registered.
- in_data, in, DATA_W: upstream payload.
- out_valid, out, 1: downstream payload valid.
- out_ready, in, 1: downstream accepts the payload.
- out_data, out, DATA_W: head payload.
- stall, in, STAGE_NUM: legacy stall vector. 1 = Stop.
- flush, in, 1: synchronous kill of all buffered payloads.
- cnt_clr, in, 1: synchronous clear of both counters.
- bubble_cnt, out, CNT_W: cycles with out_valid=0 while the consumer was ready.
- bp_cnt, out, CNT_W: cycles with out_valid=1 while the consumer was not ready.
- occ, out, 2: current occupancy, 0..2.

Behaviour:
- Effective handshake signals:
  - push = in_valid & in_ready & ~stall[STAGE_IDX-1]
  - pop = out_valid & out_ready & ~stall[STAGE_IDX]
- Storage: main entry (head) plus skid entry. FSM states EMPTY, ONE, TWO. occ is 0, 1 or 2 respectively.
- FSM transitions, when flush=0:
  - EMPTY: push -> ONE (main <= in_data).
  - ONE: push & ~pop -> TWO (skid <= in_data). ~push & pop -> EMPTY. push & pop -> ONE (main <= in_data).
  - TWO: pop -> ONE (main <= skid). push cannot occur in TWO because in_ready=0.
- in_ready is registered:
  - in_ready = 1 in EMPTY and ONE, 0 in TWO.
  - After reset or flush, in_ready = 1.
  - Next-cycle value is 0 only when the FSM enters TWO.
- out_valid = (state != EMPTY). out_data = main entry.
  - If ZERO_INVALID=1 and state=EMPTY, out_data = 0.
- Latency: 1 cycle from push to out_valid when the buffer is empty. No combinational in->out path on valid, data or ready.
- Legacy bubble: stall[STAGE_IDX-1]=1 with stall[STAGE_IDX]=0 suppresses push while pops continue. This drains the buffer and yields NOP bubbles, matching the classic "upstream stopped, this stage running" rule.
- stall[STAGE_IDX]=1 freezes the head: no pop, and out_data stays stable.
- flush=1, highest priority:
  - Next state EMPTY, both entries zeroed, in_ready=1.
  - A push or pop in the same cycle is discarded and not counted as a transfer.
  - Counters still update for that cycle.
- Counters:
  - bubble_cnt += 1 when ~out_valid & out_ready & ~stall[STAGE_IDX].
  - bp_cnt += 1 when out_valid & ~(out_ready & ~stall[STAGE_IDX]).
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr has priority over increment: result is 0 that cycle.
- Reset (async, any time, including mid-transfer): state EMPTY, main and skid entries 0, in_ready 1, out_valid 0, out_data 0, occ 0, bubble_cnt 0, bp_cnt 0. On release, the first push is accepted at the first rising edge with rstn=1.
- Data ordering: strict FIFO. The skid entry is never bypassed by a newer push.
- X-safety: in_data is not sampled unless push=1.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum logic [1:0] {PB_EMPTY, PB_ONE, PB_TWO} pb_state_e
  - Stop/NoStop constants and STAGE_NUM default
  - stage index constants (IF_STAGE..WB_STAGE)
  - packed payload structs per stage boundary (e.g. ex_mem_pl_t), so DATA_W = $bits(struct) at instantiation
- One sub-module: pb_sat_counter (CNT_W, inc, clr -> cnt, saturating). Instantiated twice.

Test Plan:
- Reset/fill: rstn low for 2 cycles, then in_valid=1 with data 0xA1, out_ready=1 -> out_valid=1 with out_data=0xA1 one cycle later; occ=1; in_ready stays 1.
- Skid fill: push 0x11 then 0x22 with out_ready=0 -> occ=2, in_ready=0 next cycle, bp_cnt increments each cycle. Raise out_ready -> pops 0x11 then 0x22 in order, in_ready returns to 1.
- Legacy stall: stall[STAGE_IDX-1]=1, stall[STAGE_IDX]=0, in_valid=1, one entry 0x33 buffered -> 0x33 pops, out_valid=0 with out_data=0, bubble_cnt increments while upstream is stalled. Also set stall[STAGE_IDX]=1 -> out_data holds at a stable value.
- Flush with simultaneous push: occ=2 (0x44, 0x55), flush=1 with in_valid=1 (0x66) -> next cycle occ=0, out_valid=0, in_ready=1; 0x66 never appears.
- Counter saturation: CNT_W=4, hold out_ready=1 with no input for 20 cycles -> bubble_cnt=15 and stays 15. cnt_clr=1 with an increment condition present -> 0.
- Throughput: continuous in_valid and out_ready for 100 payloads (incrementing 0..99) -> one pop per cycle after the first, order preserved, occ never exceeds 1, bp_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types, stage indices and inter-stage payload layouts.
package pipe_pkg;

    typedef enum logic [1:0] {PB_EMPTY, PB_ONE, PB_TWO} pb_state_e;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int PIPE_STAGE_NUM = 6;
    localparam int IF_STAGE  = 0;
    localparam int ID_STAGE  = 1;
    localparam int EX_STAGE  = 2;
    localparam int MEM_STAGE = 3;
    localparam int WB_STAGE  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_pl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [15:0] ctrl;
    } id_ex_pl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [7:0]  ctrl;
    } ex_mem_pl_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] wdata;
    } mem_wb_pl_t;

endpackage

// File: rtl/pb_sat_counter.sv
// pb_sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module pb_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic 2-entry skid buffer between pipeline stages with legacy stall,
// flush and saturating bubble/back-pressure counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W       = 128,
    parameter int STAGE_NUM    = PIPE_STAGE_NUM,
    parameter int STAGE_IDX    = MEM_STAGE,
    parameter bit ZERO_INVALID = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    input  logic [STAGE_NUM-1:0] stall,
    input  logic                 flush,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     bp_cnt,
    output logic [1:0]           occ
);

    pb_state_e         state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt, skid_q, skid_nxt;
    logic              in_ready_q;
    logic              up_run, dn_run, push, pop;
    logic              unused_stall;

    assign unused_stall = ^stall;
    assign up_run    = (stall[STAGE_IDX-1] == NO_STOP);
    assign dn_run    = (stall[STAGE_IDX] == NO_STOP);
    assign in_ready  = in_ready_q;
    assign out_valid = (state != PB_EMPTY);
    assign push      = in_valid && in_ready_q && up_run;
    assign pop       = out_valid && out_ready && dn_run;
    assign out_data  = (ZERO_INVALID && !out_valid) ? '0 : main_q;
    assign occ       = (state == PB_TWO) ? 2'd2 : (state == PB_ONE) ? 2'd1 : 2'd0;

    // in_data is only routed into storage under push, so X on an idle bus never lands.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = PB_EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                PB_EMPTY: begin
                    state_nxt = push ? PB_ONE : PB_EMPTY;
                    main_nxt  = push ? in_data : main_q;
                end
                PB_ONE: begin
                    state_nxt = (push && !pop) ? PB_TWO : (!push && pop) ? PB_EMPTY : PB_ONE;
                    main_nxt  = (push && pop) ? in_data : main_q;
                    skid_nxt  = (push && !pop) ? in_data : skid_q;
                end
                PB_TWO: begin
                    state_nxt = pop ? PB_ONE : PB_TWO;
                    main_nxt  = pop ? skid_q : main_q;
                end
                default: state_nxt = PB_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= PB_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            in_ready_q <= (state_nxt != PB_TWO);
        end
    end

    pb_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (!out_valid && out_ready && dn_run),
        .clr  (cnt_clr),
        .cnt  (bubble_cnt)
    );

    pb_sat_counter #(.CNT_W(CNT_W)) u_bp_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (out_valid && !(out_ready && dn_run)),
        .clr  (cnt_clr),
        .cnt  (bp_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf; a negedge monitor checks every cycle.
module tb_pipe_stage_buf;

    localparam int DW = 8;
    localparam int SN = 6;
    localparam int SI = 3;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [SN-1:0] stall = '0;
    logic          flush = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] bubble_cnt, bp_cnt;
    logic [1:0]    occ;

    int total = 0;
    int bad = 0;
    int pops = 0;
    int max_occ = 0;
    logic [DW-1:0] q[$];
    logic [CW-1:0] m_bubble = '0, m_bp = '0;

    pipe_stage_buf #(
        .DATA_W(DW), .STAGE_NUM(SN), .STAGE_IDX(SI), .ZERO_INVALID(1'b1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .stall(stall),
        .flush(flush), .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt), .bp_cnt(bp_cnt), .occ(occ)
    );

    always #5 clk = ~clk;

    // Scoreboard: q holds exactly what the buffer should contain; transfers resolve at the next posedge.
    always @(negedge clk) begin
        logic mv, mr, mpush, mpop;
        logic [DW-1:0] exp_d;
        if (!rstn) begin
            q.delete();
            m_bubble = '0;
            m_bp = '0;
        end else begin
            mv = (q.size() != 0);
            mr = (q.size() < 2);
            exp_d = mv ? q[0] : '0;
            if (q.size() > max_occ) max_occ = q.size();
            total++; if (occ !== 2'(q.size())) begin bad++; $display("FAIL mon_occ got=%0d want=%0d", occ, q.size()); end
            total++; if (out_valid !== mv) begin bad++; $display("FAIL mon_valid got=%b want=%b", out_valid, mv); end
            total++; if (out_data !== exp_d) begin bad++; $display("FAIL mon_data got=%h want=%h", out_data, exp_d); end
            total++; if (in_ready !== mr) begin bad++; $display("FAIL mon_in_ready got=%b want=%b", in_ready, mr); end
            total++; if (bubble_cnt !== m_bubble) begin bad++; $display("FAIL mon_bubble got=%0d want=%0d", bubble_cnt, m_bubble); end
            total++; if (bp_cnt !== m_bp) begin bad++; $display("FAIL mon_bp got=%0d want=%0d", bp_cnt, m_bp); end
            mpop  = mv && out_ready && !stall[SI];
            mpush = in_valid && mr && !stall[SI-1];
            if (cnt_clr) begin
                m_bubble = '0;
                m_bp = '0;
            end else begin
                if (!mv && out_ready && !stall[SI] && m_bubble != CMAX) m_bubble = m_bubble + 1'b1;
                if (mv && !(out_ready && !stall[SI]) && m_bp != CMAX) m_bp = m_bp + 1'b1;
            end
            if (flush) q.delete();
            else begin
                if (mpop) begin void'(q.pop_front()); pops++; end
                if (mpush) q.push_back(in_data);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cyc(2);
        total++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL reset_out occ=%0d valid=%b data=%h want 0/0/00", occ, out_valid, out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (bubble_cnt !== '0 || bp_cnt !== '0) begin bad++; $display("FAIL reset_cnt bubble=%0d bp=%0d want 0/0", bubble_cnt, bp_cnt); end
        rstn = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin bad++; $display("FAIL fill_first valid=%b data=%h want 1/a1", out_valid, out_data); end
        total++; if (occ !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL fill_occ occ=%0d in_ready=%b want 1/1", occ, in_ready); end
        cyc();
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL fill_drain occ=%0d want=0", occ); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        clr_cnt();
        in_valid = 1'b1;
        in_data = 8'h11;
        cyc();
        in_data = 8'h22;
        cyc();
        in_valid = 1'b0;
        total++; if (occ !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL skid_full occ=%0d in_ready=%b want 2/0", occ, in_ready); end
        total++; if (out_data !== 8'h11 || bp_cnt !== 4'd1) begin bad++; $display("FAIL skid_head data=%h bp=%0d want 11/1", out_data, bp_cnt); end
        cyc();
        total++; if (bp_cnt !== 4'd2) begin bad++; $display("FAIL skid_bp got=%0d want=2", bp_cnt); end
        out_ready = 1'b1;
        cyc();
        total++; if (out_data !== 8'h22 || occ !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL skid_pop1 data=%h occ=%0d in_ready=%b want 22/1/1", out_data, occ, in_ready); end
        for (int i = 0; i < 10 && occ != 2'd0; i++) cyc();
        total++; if (occ !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL skid_drain occ=%0d in_ready=%b want 0/1 within budget", occ, in_ready); end
    endtask

    task automatic test_legacy_stall();
        out_ready = 1'b0;
        clr_cnt();
        in_valid = 1'b1;
        in_data = 8'h33;
        cyc();
        stall[SI-1] = 1'b1;
        in_data = 8'h77;
        out_ready = 1'b1;
        cyc();
        total++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL lstall_bubble occ=%0d valid=%b data=%h want 0/0/00", occ, out_valid, out_data); end
        cyc(2);
        total++; if (bubble_cnt !== 4'd2) begin bad++; $display("FAIL lstall_bubble_cnt got=%0d want=2", bubble_cnt); end
        stall[SI-1] = 1'b0;
        stall[SI] = 1'b1;
        in_data = 8'h88;
        cyc();
        in_valid = 1'b0;
        cyc(3);
        total++; if (out_data !== 8'h88 || occ !== 2'd1) begin bad++; $display("FAIL lstall_hold data=%h occ=%0d want 88/1", out_data, occ); end
        stall[SI] = 1'b0;
        cyc();
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL lstall_release occ=%0d want=0", occ); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h44;
        cyc();
        in_data = 8'h55;
        cyc();
        total++; if (occ !== 2'd2) begin bad++; $display("FAIL flush_pre occ=%0d want=2", occ); end
        flush = 1'b1;
        in_data = 8'h66;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin bad++; $display("FAIL flush_two occ=%0d valid=%b in_ready=%b data=%h want 0/0/1/00", occ, out_valid, in_ready, out_data); end
        in_valid = 1'b1;
        in_data = 8'h99;
        cyc();
        flush = 1'b1;
        in_data = 8'h66;
        out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (occ !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_push occ=%0d valid=%b want 0/0", occ, out_valid); end
        cyc(2);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost valid=%b want=0", out_valid); end
    endtask

    task automatic test_saturation();
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_cnt();
        cyc(20);
        total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_bubble got=%0d want=15", bubble_cnt); end
        cyc(2);
        total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", bubble_cnt); end
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL sat_clr got=%0d want=0", bubble_cnt); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        clr_cnt();
        pops = 0;
        max_occ = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 8'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        total++; if (pops !== 100) begin bad++; $display("FAIL b2b_pops got=%0d want=100", pops); end
        total++; if (max_occ > 1) begin bad++; $display("FAIL b2b_occ got=%0d want<=1", max_occ); end
        total++; if (bp_cnt !== 4'd0) begin bad++; $display("FAIL b2b_bp got=%0d want=0", bp_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hC3;
        cyc();
        #2 rstn = 1'b0;
        #1;
        total++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin bad++; $display("FAIL areset occ=%0d valid=%b data=%h in_ready=%b want 0/0/00/1", occ, out_valid, out_data, in_ready); end
        @(posedge clk);
        #1 rstn = 1'b1;
        in_data = 8'h5A;
        cyc();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin bad++; $display("FAIL areset_first valid=%b data=%h want 1/5a", out_valid, out_data); end
        out_ready = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_skid();
        test_legacy_stall();
        test_flush();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
